uart_rx: RTL

// - UART receiver: 8N1 serial on rxd -> AXI4-Stream byte out. LSB first, 1 start, 1 stop, no parity.
// - Bit timing matches the uart_tx counterpart: one bit = prescale*8 clk cycles; both ends share prescale.
// - Sits between the board RX pin and the terminal command/character FIFO.

---
 rtl/uart_rx.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx: 8N1 serial receiver to AXI4-Stream; optional UART_RX_MAJORITY_EN  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  rxd,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error,
  input  logic [15:0]           prescale
);

  localparam logic [3:0] BITS = 4'(DATA_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t                state_q, state_d;
  logic                  rx_meta_q, rxs_q;
  logic [18:0]           cnt_q, cnt_d;
  logic [18:0]           bit_len_q, bit_len_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  overrun_q, overrun_d;
  logic                  frame_err_q, frame_err_d;

  logic [15:0]           w_presc;
  logic [18:0]           w_bit_len;
  logic [18:0]           w_half_m1;
  logic                  w_sample;
  logic [DATA_WIDTH-1:0] w_shifted;

  assign w_presc   = (prescale == 16'd0) ? 16'd1 : prescale;
  assign w_bit_len = {w_presc, 3'b000};
  assign w_half_m1 = {1'b0, w_presc, 2'b00} - 19'd1;

`ifdef UART_RX_MAJORITY_EN
  logic rxs_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxs_prev_q <= 1'b1;
    end else begin
      rxs_prev_q <= rxs_q;
    end
  end

  // rx_meta_q is the value rxs takes one clock later, so the +1 sample costs no latency
  assign w_sample = (rxs_prev_q & rxs_q) | (rxs_prev_q & rx_meta_q) | (rxs_q & rx_meta_q);
`else
  assign w_sample = rxs_q;
`endif

  generate
    if (DATA_WIDTH == 1) begin : g_shift_single
      assign w_shifted = w_sample;
    end else begin : g_shift_multi
      assign w_shifted = {w_sample, shift_q[DATA_WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_len_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rxd;
      rxs_q       <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_len_q   <= bit_len_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_len_d   = bit_len_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q & ~m_axis_tready;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rxs_q) begin
          state_d   = ST_START;
          bit_len_d = w_bit_len;
          cnt_d     = w_half_m1;
        end
      end
      ST_START: begin
        if (cnt_q != 19'd0) begin
          cnt_d = cnt_q - 19'd1;
        end else if (!w_sample) begin
          state_d   = ST_DATA;
          cnt_d     = bit_len_q - 19'd1;
          bit_cnt_d = BITS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (cnt_q != 19'd0) begin
          cnt_d = cnt_q - 19'd1;
        end else begin
          shift_d   = w_shifted;
          cnt_d     = bit_len_q - 19'd1;
          bit_cnt_d = bit_cnt_q - 4'd1;
          if (bit_cnt_q == 4'd1) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (cnt_q != 19'd0) begin
          cnt_d = cnt_q - 19'd1;
        end else if (w_sample) begin
          // a word accepted in this same cycle is not an overrun
          tdata_d   = shift_q;
          tvalid_d  = 1'b1;
          overrun_d = tvalid_q & ~m_axis_tready;
          state_d   = ST_IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (rxs_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign overrun_error = overrun_q;
  assign frame_error   = frame_err_q;
  assign busy          = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);

endmodule
`default_nettype wire
